// File: rtl/poly_frommsg_masked_encode_pkg.sv
// Shared constants, tag layout and mod-q helpers for the masked message encoder.
package poly_frommsg_masked_encode_pkg;

  localparam int unsigned KYBER_N  = 256;
  localparam int unsigned KYBER_Q  = 3329;
  localparam int unsigned HALF_Q   = 1665;
  localparam int unsigned COEFF_SZ = 16;
  localparam int unsigned QBITS    = 12;
  localparam int unsigned RAND_SZ  = 32;
  localparam int unsigned IDX_W    = $clog2(KYBER_N);

  typedef logic [COEFF_SZ-1:0] coeff_t;

  localparam coeff_t Q_C    = coeff_t'(KYBER_Q);
  localparam coeff_t HALF_C = coeff_t'(HALF_Q);

  typedef struct packed {
    logic             done;
    logic [IDX_W-1:0] idx;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

  function automatic coeff_t cond_reduce(input coeff_t x);
    return (x >= Q_C) ? coeff_t'(x - Q_C) : x;
  endfunction

  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
    logic [COEFF_SZ:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q_C}) s = s - {1'b0, Q_C};
    return s[COEFF_SZ-1:0];
  endfunction

  function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
    return (a >= b) ? coeff_t'(a - b) : coeff_t'(a + Q_C - b);
  endfunction

endpackage

// File: rtl/poly_frommsg_masked_encode_if.sv
// Byte-in / coefficient-out bus of the masked message encoder.
import poly_frommsg_masked_encode_pkg::*;

interface poly_frommsg_masked_encode_if;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         m1;
  logic [7:0]         m2;
  logic [RAND_SZ-1:0] PRNG_data;
  logic               out_valid;
  logic [IDX_W-1:0]   out_idx;
  logic [COEFF_SZ-1:0] y1;
  logic [COEFF_SZ-1:0] y2;
  logic               done;

  modport master (
    output in_valid, m1, m2, PRNG_data,
    input  in_ready, out_valid, out_idx, y1, y2, done
  );

  modport slave (
    input  in_valid, m1, m2, PRNG_data,
    output in_ready, out_valid, out_idx, y1, y2, done
  );
endinterface

// File: rtl/poly_frommsg_masked_encode_masked_bit_b2a.sv
// Four-stage Boolean-to-arithmetic conversion of one masked bit into mod-q shares.
import poly_frommsg_masked_encode_pkg::*;

module masked_bit_b2a #(
  parameter int unsigned TAG_W_P = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_valid,
  input  logic               b1,
  input  logic               b2,
  input  coeff_t             r0,
  input  coeff_t             r1,
  input  logic [TAG_W_P-1:0] tag_in,
  output logic [TAG_W_P-1:0] tag_out,
  output coeff_t             y1,
  output coeff_t             y2,
  output logic               valid
);

  logic v0_q, v0_d, b1_0_q, b1_0_d, b2_0_q, b2_0_d;
  coeff_t ra0_q, ra0_d, rb0_q, rb0_d;
  logic [TAG_W_P-1:0] tag0_q, tag0_d;

  logic v1_q, v1_d, b2_1_q, b2_1_d;
  coeff_t s1_1_q, s1_1_d, s2_1_q, s2_1_d, rb1_q, rb1_d;
  logic [TAG_W_P-1:0] tag1_q, tag1_d;

  logic v2_q, v2_d;
  coeff_t s1_2_q, s1_2_d, s2_2_q, s2_2_d, rb2_q, rb2_d;
  logic [TAG_W_P-1:0] tag2_q, tag2_d;

  logic v3_q, v3_d;
  coeff_t y1_3_q, y1_3_d, y2_3_q, y2_3_d;
  logic [TAG_W_P-1:0] tag3_q, tag3_d;

  logic unused_rand;
  assign unused_rand = ^{r0[COEFF_SZ-1:QBITS], r1[COEFF_SZ-1:QBITS]};

  // b1 enters at stage 1 and b2 at stage 2 so the two shares never meet in one expression.
  always_comb begin
    v0_d   = bit_valid;
    b1_0_d = b1;
    b2_0_d = b2;
    ra0_d  = cond_reduce(coeff_t'(r0[QBITS-1:0]));
    rb0_d  = cond_reduce(coeff_t'(r1[QBITS-1:0]));
    tag0_d = tag_in;

    v1_d   = v0_q;
    s1_1_d = mod_sub(b1_0_q ? HALF_C : '0, ra0_q);
    s2_1_d = ra0_q;
    b2_1_d = b2_0_q;
    rb1_d  = rb0_q;
    tag1_d = tag0_q;

    v2_d   = v1_q;
    s1_2_d = b2_1_q ? mod_sub(HALF_C, s1_1_q) : s1_1_q;
    s2_2_d = b2_1_q ? mod_sub('0, s2_1_q) : s2_1_q;
    rb2_d  = rb1_q;
    tag2_d = tag1_q;

    v3_d   = v2_q;
    y1_3_d = mod_add(s1_2_q, rb2_q);
    y2_3_d = mod_sub(s2_2_q, rb2_q);
    tag3_d = tag2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0; b1_0_q <= 1'b0; b2_0_q <= 1'b0;
      ra0_q <= '0; rb0_q <= '0; tag0_q <= '0;
      v1_q <= 1'b0; b2_1_q <= 1'b0;
      s1_1_q <= '0; s2_1_q <= '0; rb1_q <= '0; tag1_q <= '0;
      v2_q <= 1'b0;
      s1_2_q <= '0; s2_2_q <= '0; rb2_q <= '0; tag2_q <= '0;
      v3_q <= 1'b0;
      y1_3_q <= '0; y2_3_q <= '0; tag3_q <= '0;
    end else begin
      v0_q <= v0_d; b1_0_q <= b1_0_d; b2_0_q <= b2_0_d;
      ra0_q <= ra0_d; rb0_q <= rb0_d; tag0_q <= tag0_d;
      v1_q <= v1_d; b2_1_q <= b2_1_d;
      s1_1_q <= s1_1_d; s2_1_q <= s2_1_d; rb1_q <= rb1_d; tag1_q <= tag1_d;
      v2_q <= v2_d;
      s1_2_q <= s1_2_d; s2_2_q <= s2_2_d; rb2_q <= rb2_d; tag2_q <= tag2_d;
      v3_q <= v3_d;
      y1_3_q <= y1_3_d; y2_3_q <= y2_3_d; tag3_q <= tag3_d;
    end
  end

  assign valid   = v3_q;
  assign y1      = y1_3_q;
  assign y2      = y2_3_q;
  assign tag_out = tag3_q;

endmodule

// File: rtl/poly_frommsg_masked_encode.sv
// Masked message encoder: serializes masked message bytes LSB-first into the B2A pipeline.
import poly_frommsg_masked_encode_pkg::*;

module poly_frommsg_masked_encode (
  input  logic                        clk,
  input  logic                        rst,
  poly_frommsg_masked_encode_if.slave bus
);

  logic             full_q, full_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       m1_q, m1_d, m2_q, m2_d;
  logic [IDX_W-1:0] coeff_cnt_q, coeff_cnt_d;

  logic   in_ready, accept, issue;
  tag_t   tag_in, tag_out;
  coeff_t y1, y2;
  logic   out_valid;

  // Ready again on the last bit so the next byte follows with no bubble.
  always_comb begin
    in_ready    = !rst && (!full_q || (bit_cnt_q == 3'd7));
    accept      = bus.in_valid && in_ready;
    issue       = full_q;
    full_d      = full_q;
    bit_cnt_d   = bit_cnt_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    coeff_cnt_d = coeff_cnt_q;
    if (issue) begin
      coeff_cnt_d = coeff_cnt_q + 1'b1;
      bit_cnt_d   = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) full_d = 1'b0;
    end
    if (accept) begin
      m1_d      = bus.m1;
      m2_d      = bus.m2;
      bit_cnt_d = '0;
      full_d    = 1'b1;
    end
    tag_in.idx  = coeff_cnt_q;
    tag_in.done = (coeff_cnt_q == IDX_W'(KYBER_N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 1'b0;
      bit_cnt_q   <= '0;
      m1_q        <= '0;
      m2_q        <= '0;
      coeff_cnt_q <= '0;
    end else begin
      full_q      <= full_d;
      bit_cnt_q   <= bit_cnt_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      coeff_cnt_q <= coeff_cnt_d;
    end
  end

  masked_bit_b2a #(.TAG_W_P(TAG_W)) u_b2a (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (issue),
    .b1        (m1_q[bit_cnt_q]),
    .b2        (m2_q[bit_cnt_q]),
    .r0        (bus.PRNG_data[RAND_SZ-1:COEFF_SZ]),
    .r1        (bus.PRNG_data[COEFF_SZ-1:0]),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .y1        (y1),
    .y2        (y2),
    .valid     (out_valid)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = tag_out.idx;
  assign bus.done      = tag_out.done;
  assign bus.y1        = y1;
  assign bus.y2        = y2;

endmodule

// File: tb/tb_poly_frommsg_masked_encode.sv
// Scoreboard bench for the masked message encoder.
module tb_poly_frommsg_masked_encode;

  localparam int Q = 3329;
  localparam int H = 1665;

  logic clk = 1'b0;
  logic rst = 1'b1;

  poly_frommsg_masked_encode_if bus();

  poly_frommsg_masked_encode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int bitv;
    bit exact;
    int ey1;
    int ey2;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_idx = 0;
  bit   prng_rand = 1'b0;
  int   cyc = 0;
  int   run = 0;
  int   max_run = 0;
  int   t255 = -1;
  int   wrap_gap = -1;
  int   done_cnt = 0;
  time  last_acc = 0;
  time  this_acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hand-derived share values. mode 1: PRNG=0 (ra=rb=0); mode 2: PRNG all ones (ra=rb=766).
  function automatic void exact_lut(input int mode, input bit b1, input bit b2,
                                    output int y1, output int y2);
    y1 = 0;
    y2 = 0;
    if (mode == 1) begin
      y1 = (b1 ^ b2) ? 1665 : 0;
      y2 = 0;
    end else if (mode == 2) begin
      case ({b1, b2})
        2'b00: begin y1 = 0;    y2 = 0;    end
        2'b10: begin y1 = 1665; y2 = 0;    end
        2'b01: begin y1 = 3197; y2 = 1797; end
        default: begin y1 = 1532; y2 = 1797; end
      endcase
    end
  endfunction

  always @(negedge clk) begin
    if (prng_rand) bus.PRNG_data = $urandom;
  end

  always @(negedge clk) begin
    exp_t e;
    int   s;
    cyc++;
    if (!rst) begin
      if (bus.out_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (bus.done) done_cnt++;
        if (bus.out_idx == 8'd255) t255 = cyc;
        else if (bus.out_idx == 8'd0 && t255 >= 0 && wrap_gap < 0) wrap_gap = cyc - t255;
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_idx", int'(bus.out_idx), e.idx);
          s = (int'(bus.y1) + int'(bus.y2)) % Q;
          chk("share_sum", s, (e.bitv != 0) ? H : 0);
          chk("y1_range", int'(int'(bus.y1) < Q), 1);
          chk("y2_range", int'(int'(bus.y2) < Q), 1);
          chk("done_at_idx", int'(bus.done), int'(e.idx == 255));
          if (e.exact) begin
            chk("y1_exact", int'(bus.y1), e.ey1);
            chk("y2_exact", int'(bus.y2), e.ey2);
          end
        end
      end else begin
        run = 0;
        chk("done_idle", int'(bus.done), 0);
      end
    end
  end

  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int mode);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.m1 = a;
    bus.m2 = b;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
          e.idx   = exp_idx;
          e.bitv  = int'(a[j] ^ b[j]);
          e.exact = (mode != 0);
          exact_lut(mode, a[j], b[j], e.ey1, e.ey2);
          sb.push_back(e);
          exp_idx = (exp_idx + 1) % 256;
        end
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    this_acc = $time;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    int w;
    bus.in_valid  = 1'b0;
    bus.m1        = '0;
    bus.m2        = '0;
    bus.PRNG_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_y1", int'(bus.y1), 0);
    chk("rst_y2", int'(bus.y2), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5 unmasked, zero randomness, plus first-output latency
    feed(8'hA5, 8'h00, 1);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_latency", lat, 5);
    idle(12);

    // equal shares with maximal randomness slice
    bus.PRNG_data = 32'hFFFF_FFFF;
    feed(8'h5A, 8'h5A, 2);
    bus.in_valid = 1'b0;
    idx_wait_done: idle(14);

    // b2 negation paths
    bus.PRNG_data = '0;
    feed(8'hFF, 8'hFF, 1);
    feed(8'h00, 8'hFF, 1);
    bus.in_valid = 1'b0;
    idle(16);

    // mid-polynomial reset at coefficient 100
    prng_rand = 1'b1;
    for (int i = 0; i < 10; i++) feed(8'($urandom), 8'($urandom), 0);
    bus.in_valid = 1'b0;
    w = 0;
    while (!(bus.out_valid && bus.out_idx == 8'd100) && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("reach_idx100", int'(w < 100), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_y1", int'(bus.y1), 0);
    chk("midrst_y2", int'(bus.y2), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    sb.delete();
    exp_idx = 0;
    rst = 1'b0;
    idle(4);

    // two full polynomials back to back with in_valid held high
    max_run  = 0;
    t255     = -1;
    wrap_gap = -1;
    done_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      feed(8'($urandom), 8'($urandom), 0);
      if (i > 0) chk("accept_gap", int'((this_acc - last_acc) / 10), 8);
      last_acc = this_acc;
    end
    bus.in_valid = 1'b0;
    idle(20);
    prng_rand = 1'b0;
    chk("consecutive_valid", max_run, 512);
    chk("wrap_gap", wrap_gap, 1);
    chk("done_count", done_cnt, 2);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/poly_frommsg_masked_encode.md
Name: poly_frommsg_masked_encode

Overview:
Masked Kyber message encoder. This is the inverse of the masked poly-to-message decode.
- Input: 32 Boolean-masked message bytes as share pairs (m1, m2), with m = m1 ^ m2.
- Output: 256 arithmetic-masked coefficient share pairs (y1, y2), with y1 + y2 ≡ bit*HALF_Q (mod q).
- Sits between the masked decapsulation message buffer and the re-encryption polynomial RAM.

Parameters:
KYBER_N, 256, coefficients per polynomial
KYBER_Q, 3329, modulus
HALF_Q, 1665, (q+1)/2, encoding of a 1 bit
COEFF_SZ, 16, coefficient share width
QBITS, 12, random bits used per mask
RAND_SZ, 32, PRNG word width (two COEFF_SZ slices)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  byte share pair offered
in_ready  output  1  block accepts byte this cycle
m1  input  8  message byte share 1
m2  input  8  message byte share 2
PRNG_data  input  RAND_SZ  fresh randomness every cycle; [31:16]=R0, [15:0]=R1
out_valid  output  1  coefficient share pair valid
out_idx  output  8  coefficient index 0..255
y1  output  COEFF_SZ  arithmetic share 1, range [0,q)
y2  output  COEFF_SZ  arithmetic share 2, range [0,q)
done  output  1  one-cycle pulse with coefficient 255

Behaviour:
- Reset (synchronous, active-high, clk and rst only):
  - Clears the byte register, bit_cnt, coeff_cnt and all pipeline valid bits.
  - Holds y1, y2, out_idx, out_valid and done at 0.
  - in_ready=0 during the reset cycle.
  - Reset mid-polynomial discards all in-flight data. The next polynomial restarts at index 0.
- Serializer:
  - Byte register has a full flag and a 3-bit bit_cnt.
  - in_ready = !full || (bit_cnt==7). This gives a back-to-back byte stream at 8 cycles per byte with no bubble.
  - A byte is accepted on in_valid && in_ready. Acceptance loads the byte and sets bit_cnt=0.
  - While full, one bit pair (b1=m1[bit_cnt], b2=m2[bit_cnt]) is issued per cycle, LSB first.
  - Coefficient 8*i+j = bit j of byte i.
  - full clears after bit 7 unless a new byte is accepted in the same cycle.
  - No output backpressure. Downstream must accept a coefficient every cycle.
- Masked bit B2A pipeline: fixed latency 4 cycles from bit issue to out_valid. out_idx and done travel with the data.
  - Stage 0:
    - ra = R0[11:0], rb = R1[11:0].
    - Each is reduced by one conditional subtract of q if >= q. The slight bias is accepted.
    - Latch b1, b2.
  - Stage 1: s1 = (b1*HALF_Q - ra) mod q; s2 = ra.
  - Stage 2:
    - If b2: s1 := (HALF_Q - s1) mod q; s2 := (q - s2) mod q, with 0 mapping to 0.
    - Otherwise pass through.
    - b1 and b2 must never be combined in one expression.
  - Stage 3 (refresh): y1 = (s1 + rb) mod q; y2 = (s2 - rb) mod q.
- Modular add and subtract use one conditional correction. Results stay in [0,q) at every stage.
- coeff_cnt increments per issued bit and wraps 255->0. done is asserted with out_idx=255.
- Each stage consumes the PRNG_data of the cycle in which that stage's data is registered. Exact slicing: R0 feeds stage 0; R1 is registered alongside and feeds stage 3.
- in_valid while !in_ready is ignored. The bench must hold data.

Decomposition:
- Shared package: KYBER_N, KYBER_Q, HALF_Q, QBITS, plus mod-q add/sub/conditional-reduce functions.
- One sub-module, masked_bit_b2a: the 4-stage pipeline with ports clk, rst, bit_valid, b1, b2, rand pair, tag in, tag out, y1, y2, valid.
- Top-level module holds only the serializer, the counters and done generation.

Test Plan:
- PRNG_data=0; m1=0xA5, m2=0x00 -> idx 0..7 have (y1+y2) mod q = 1665,0,1665,0,0,1665,0,1665; first out_valid 4 cycles after first bit issue.
- m1=m2=0x5A, PRNG_data=0xFFFF_FFFF -> ra=rb=766; all 8 sums = 0; every y1, y2 < 3329.
- b1=1, b2=1, PRNG_data=0 -> s1=1665, negated to 0 -> y1=0, y2=0; b1=0, b2=1 -> y1=1665, y2=0.
- 32 bytes with in_valid held high, random m1, m2, PRNG -> in_ready pulses every 8th cycle; 256 consecutive out_valid; done only with idx 255; all sums match the unmasked reference.
- rst asserted at coefficient 100 -> next cycle out_valid=0, y1=y2=0; new stream starts at idx 0.
- Second polynomial immediately after done -> out_idx wraps 255->0 with no gap.
